// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : round-robin share of one sync data RAM + MMIO output register
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int          MEM_WORDS = 1024,
    parameter int          AW        = 10,
    parameter logic [31:0] MMIO_ADDR = 32'h20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          mmio_we,
    output logic [31:0]   mmio_data
);

    localparam logic [32:0] RAM_BYTES = 33'(4 * MEM_WORDS);

    logic        last_q, last_d;     // 1 = m1 was granted most recently
    logic        rsp_vld_q, rsp_own_q, rsp_rd_q, rsp_mmio_q, rsp_err_q;
    logic        mmio_we_q;
    logic [31:0] mmio_q, mmio_d;

    logic        gnt0, gnt1, any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic        misaligned, hit_mmio, hit_ram, acc_err;
    logic [31:0] rsp_rdata;

    // Grants are suppressed while reset is asserted so every output reads 0.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (m0_req && m1_req) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_we    = gnt1 ? m1_we    : m0_we;
    assign sel_addr  = gnt1 ? m1_addr  : m0_addr;
    assign sel_wdata = gnt1 ? m1_wdata : m0_wdata;

    assign misaligned = |sel_addr[1:0];
    assign hit_mmio   = !misaligned && (sel_addr == MMIO_ADDR);
    assign hit_ram    = !misaligned && !hit_mmio && ({1'b0, sel_addr} < RAM_BYTES);
    assign acc_err    = !hit_mmio && !hit_ram;

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign mem_en    = any_gnt && hit_ram;
    assign mem_we    = mem_en && sel_we;
    assign mem_addr  = mem_en ? sel_addr[AW+1:2] : '0;
    assign mem_wdata = mem_we ? sel_wdata : '0;

    assign last_d = any_gnt ? gnt1 : last_q;
    assign mmio_d = (any_gnt && hit_mmio && sel_we) ? sel_wdata : mmio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= 1'b1;
            rsp_vld_q  <= 1'b0;
            rsp_own_q  <= 1'b0;
            rsp_rd_q   <= 1'b0;
            rsp_mmio_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            mmio_we_q  <= 1'b0;
            mmio_q     <= '0;
        end else begin
            last_q     <= last_d;
            rsp_vld_q  <= any_gnt;
            rsp_own_q  <= gnt1;
            rsp_rd_q   <= !sel_we;
            rsp_mmio_q <= hit_mmio;
            rsp_err_q  <= acc_err;
            mmio_we_q  <= any_gnt && hit_mmio && sel_we;
            mmio_q     <= mmio_d;
        end
    end

    // MMIO reads see the register as it stands during the response cycle.
    assign rsp_rdata = (rsp_vld_q && rsp_rd_q && !rsp_err_q)
                     ? (rsp_mmio_q ? mmio_q : mem_rdata) : '0;

    assign m0_rvalid = rsp_vld_q && !rsp_own_q;
    assign m1_rvalid = rsp_vld_q &&  rsp_own_q;
    assign m0_rdata  = m0_rvalid ? rsp_rdata : '0;
    assign m1_rdata  = m1_rvalid ? rsp_rdata : '0;
    assign m0_err    = m0_rvalid && rsp_err_q;
    assign m1_err    = m1_rvalid && rsp_err_q;
    assign mmio_we   = mmio_we_q;
    assign mmio_data = mmio_q;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data RAM, plus the word-wide MMIO output register, between two requesters.
- Requester 0 is the CPU data port. Requester 1 is the debug/program loader.
- Round-robin arbitration; one access issued per cycle; read data returned with fixed 1-cycle latency.
- Decodes the MMIO address and flags out-of-range or misaligned accesses as errors.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-1.
- AW, 10, RAM word-address width; must satisfy 2**AW >= MEM_WORDS.
- MMIO_ADDR, 32'h20, byte address of the MMIO output register; takes precedence over RAM decode.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  CPU access request.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address.
- m0_wdata  in  32  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  response valid.
- m0_rdata  out  32  read data.
- m0_err  out  1  error flag, qualified by m0_rvalid.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as the m0_* ports, for the loader.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM word address (byte addr[AW+1:2]).
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid the cycle after mem_en with mem_we=0.
- mmio_we  out  1  one-cycle pulse on an MMIO write.
- mmio_data  out  32  MMIO register contents.

Behaviour:
- Reset (async): all outputs 0; mmio_data 0; last-grant pointer = 1, so m0 wins the first contention.
- Grant is combinational in the issue cycle.
  - Only one req high: that requester is granted.
  - Both high: grant goes to the requester not granted last; pointer updates on every grant.
  - Exactly one gnt per cycle at most.
- Handshake:
  - A requester holds req, we, addr, wdata stable until its gnt is seen high on a clock edge.
  - The transaction is accepted on that edge.
  - req may be dropped at any time before a grant with no side effect.
- Decode of the granted access, in priority order:
  1. addr[1:0] != 0 → error.
  2. addr == MMIO_ADDR → MMIO.
  3. addr < 4*MEM_WORDS → RAM.
  4. Anything else → error.
- RAM access: mem_en=1, mem_we=we, mem_addr, mem_wdata driven in the issue cycle.
- MMIO write: mmio_data updated on the issue edge; mmio_we pulses high for the cycle after the issue edge.
- Error access: no RAM enable and no MMIO update.
- Response for every granted access, reads and writes alike, comes exactly one cycle after the issue cycle:
  - The granted requester's rvalid=1 for one cycle.
  - Reads: rdata = mem_rdata for RAM, mmio_data (value before any same-cycle write) for MMIO, 0 for errors.
  - Writes: rdata = 0.
  - err=1 only for error accesses.
- A 1-deep response pipeline register holds {owner, kind, err}; its valid bit clears when no grant is issued.
- Back-to-back: a new grant may issue in the same cycle as the previous response, giving 1 access/cycle sustained.
- Alternating arbitration under continuous contention: m0, m1, m0, m1, …
- rvalid is never asserted to a requester that was not granted in the preceding cycle.
- Reset mid-operation: a pending response is dropped; no rvalid after rst_n deasserts until a new grant.

Test Plan:
- After reset, m0 writes 0xDEADBEEF to 0x40, then reads 0x40 → write rvalid next cycle, err=0; read rvalid next cycle, rdata=0xDEADBEEF; mem_addr=0x10 on both issues.
- m0 and m1 both hold req for 6 cycles with reads of 0x0/0x4 → gnt sequence m0,m1,m0,m1,m0,m1; each rvalid lands one cycle after its gnt with the matching data.
- m1 writes 0x41 to 0x20 → mem_en stays 0; mmio_we pulses once one cycle after issue; mmio_data=0x41; a following read of 0x20 returns 0x41.
- m0 reads 0x2 (misaligned) and m1 reads 4*MEM_WORDS (0x1000) → no mem_en; rvalid with err=1, rdata=0; arbitration pointer still advances.
- m1 holds req with m0 idle for 4 cycles → 4 consecutive m1 grants. m0 then raises req while m1 is still requesting → m0 is granted next.
- Assert rst_n low the cycle after a read grant → no rvalid; all outputs 0; mmio_data 0. After release, m0 wins the first contention.
